// File: rtl/spiker_adapter_pkg.sv
// Shared types and helpers for the spiker input path (spiker_reader and
// its frame buffer).
package spiker_adapter_pkg;

  // Presentation FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2,
    DONE    = 2'd3
  } reader_state_e;

  // Default geometry of the core input vector
  localparam int DEF_DATA_WIDTH = 800;
  localparam int DEF_N_SPIKES   = 784;

  // Zero-padded tail of the core input vector above the meaningful spikes
  localparam int SPIKE_PAD_W = DEF_DATA_WIDTH - DEF_N_SPIKES;

  // Number of register words needed to cover a vector of 'bits' bits
  function automatic int ceil_words(input int bits, input int word_w);
    return (bits + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/spiker_frame_buffer.sv
// Shadow buffer for the input spike frame. Holds N_REG register words and
// a per-word dirty mask. A write in the current cycle is bypassed onto the
// shadow vector and the all_dirty flag, so a start issued in the same cycle
// as the last write sees that write.
module spiker_frame_buffer #(
  parameter int WIDTH = 32,
  parameter int N_REG = 25,
  parameter int AW    = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   clear_dirty_i,
  output logic [N_REG*WIDTH-1:0] shadow_o,
  output logic                   all_dirty_o
);

  logic [N_REG-1:0] dirty_view;

  genvar gi;
  generate
    for (gi = 0; gi < N_REG; gi++) begin : g_word
      localparam logic [AW-1:0] IDX = AW'(gi);

      logic [WIDTH-1:0] word_reg;
      logic             dirty_reg;
      logic             hit;

      // Addresses at or above N_REG never match any word, so they are dropped
      assign hit = we_i && (waddr_i == IDX);

      // Word storage and dirty bit; a start-time clear wins over a same-cycle
      // write because that write was already bypassed into the started frame
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          word_reg  <= '0;
          dirty_reg <= 1'b0;
        end else begin
          if (hit) begin
            word_reg <= wdata_i;
          end
          if (clear_dirty_i) begin
            dirty_reg <= 1'b0;
          end else if (hit) begin
            dirty_reg <= 1'b1;
          end
        end
      end

      assign shadow_o[gi*WIDTH +: WIDTH] = hit ? wdata_i : word_reg;
      assign dirty_view[gi]              = dirty_reg | hit;
    end
  endgenerate

  assign all_dirty_o = &dirty_view;

endmodule

// File: rtl/spiker_reader.sv
// Spiker input reader: collects a spike frame from the register file into a
// shadow buffer and, on start, presents a frozen copy to the spiker core for
// a programmed number of timesteps with a valid/ready handshake per step.
// Optional build macro SPIKER_READER_FULL_CHECK_EN: when defined, a start is
// only accepted once every spike word has been written since the last start.
module spiker_reader
  import spiker_adapter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int N_SPIKES   = 784,
  parameter int DATA_WIDTH = 800,
  parameter int N_REG      = 25,
  parameter int STEP_W     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       reg_we_i,
  input  logic [$clog2(N_REG)-1:0]   reg_waddr_i,
  input  logic [WIDTH-1:0]           reg_wdata_i,
  input  logic                       start_i,
  input  logic [STEP_W-1:0]          n_steps_i,
  input  logic                       clear_err_i,
  output logic [DATA_WIDTH-1:0]      data_in_o,
  output logic                       data_valid_o,
  input  logic                       core_ready_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [STEP_W-1:0]          step_count_o,
  output logic                       err_o
);

  localparam int AW      = $clog2(N_REG);
  localparam int BUF_W   = N_REG * WIDTH;
  localparam int MIN_REG = ceil_words(DATA_WIDTH, WIDTH);

  // Elaboration-time guard: an undefined module stops the build on a bad
  // geometry instead of silently truncating the frame
  generate
    if (N_REG < MIN_REG || N_SPIKES > DATA_WIDTH) begin : g_bad_geometry
      spiker_reader_bad_geometry u_bad_geometry ();
    end
  endgenerate

  reader_state_e state_reg, state_next;

  logic [DATA_WIDTH-1:0] frame_reg, frame_next;
  logic [STEP_W-1:0]     target_reg, target_next;
  logic [STEP_W-1:0]     count_reg, count_next;
  logic                  err_reg, err_next;
  logic                  err_event;
  logic                  clear_dirty;
  logic                  start_ok;
  logic [BUF_W-1:0]      shadow_vec;
  logic                  all_dirty;

  spiker_frame_buffer #(
    .WIDTH (WIDTH),
    .N_REG (N_REG),
    .AW    (AW)
  ) u_frame_buffer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .we_i          (reg_we_i),
    .waddr_i       (reg_waddr_i),
    .wdata_i       (reg_wdata_i),
    .clear_dirty_i (clear_dirty),
    .shadow_o      (shadow_vec),
    .all_dirty_o   (all_dirty)
  );

`ifdef SPIKER_READER_FULL_CHECK_EN
  assign start_ok = (n_steps_i != '0) && all_dirty;
`else
  assign start_ok = (n_steps_i != '0);

  // Dirty tracking is kept but not consulted in this build
  logic unused_all_dirty;
  assign unused_all_dirty = all_dirty;
`endif

  // Shadow bits above the meaningful spikes never reach the core
  generate
    if (N_SPIKES < BUF_W) begin : g_unused_tail
      logic unused_shadow_tail;
      assign unused_shadow_tail = ^shadow_vec[BUF_W-1:N_SPIKES];
    end
  endgenerate

  // Next-state, frame capture, step counting and error detection
  always_comb begin
    state_next  = state_reg;
    frame_next  = frame_reg;
    target_next = target_reg;
    count_next  = count_reg;
    clear_dirty = 1'b0;
    err_event   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (start_ok) begin
            // Pad bits above N_SPIKES come out as zero from the extension
            frame_next  = DATA_WIDTH'(shadow_vec[N_SPIKES-1:0]);
            target_next = n_steps_i;
            count_next  = '0;
            clear_dirty = 1'b1;
            state_next  = PRESENT;
          end else begin
            err_event = 1'b1;
          end
        end
      end
      PRESENT: begin
        err_event = start_i;
        if (core_ready_i) begin
          count_next = count_reg + STEP_W'(1);
          state_next = (count_next == target_reg) ? DONE : GAP;
        end
      end
      GAP: begin
        err_event  = start_i;
        state_next = PRESENT;
      end
      DONE: begin
        err_event  = start_i;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A fresh error outranks a same-cycle clear
    if (err_event) begin
      err_next = 1'b1;
    end else if (clear_err_i) begin
      err_next = 1'b0;
    end else begin
      err_next = err_reg;
    end
  end

  // State and datapath registers; reset abandons any in-flight timestep
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      frame_reg  <= '0;
      target_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      frame_reg  <= frame_next;
      target_reg <= target_next;
      count_reg  <= count_next;
      err_reg    <= err_next;
    end
  end

  assign data_in_o    = frame_reg;
  assign data_valid_o = (state_reg == PRESENT);
  assign busy_o       = (state_reg != IDLE);
  assign done_o       = (state_reg == DONE);
  assign step_count_o = count_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_spiker_reader.sv
// Directed, table-driven bench for spiker_reader.
module tb_spiker_reader;

  localparam int WIDTH      = 32;
  localparam int N_SPIKES   = 784;
  localparam int DATA_WIDTH = 800;
  localparam int N_REG      = 25;
  localparam int STEP_W     = 4;
  localparam int AW         = 5;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  reg_we_i = 1'b0;
  logic [AW-1:0]         reg_waddr_i = '0;
  logic [WIDTH-1:0]      reg_wdata_i = '0;
  logic                  start_i = 1'b0;
  logic [STEP_W-1:0]     n_steps_i = '0;
  logic                  clear_err_i = 1'b0;
  logic [DATA_WIDTH-1:0] data_in_o;
  logic                  data_valid_o;
  logic                  core_ready_i = 1'b0;
  logic                  busy_o;
  logic                  done_o;
  logic [STEP_W-1:0]     step_count_o;
  logic                  err_o;

  spiker_reader #(
    .WIDTH      (WIDTH),
    .N_SPIKES   (N_SPIKES),
    .DATA_WIDTH (DATA_WIDTH),
    .N_REG      (N_REG),
    .STEP_W     (STEP_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .reg_we_i     (reg_we_i),
    .reg_waddr_i  (reg_waddr_i),
    .reg_wdata_i  (reg_wdata_i),
    .start_i      (start_i),
    .n_steps_i    (n_steps_i),
    .clear_err_i  (clear_err_i),
    .data_in_o    (data_in_o),
    .data_valid_o (data_valid_o),
    .core_ready_i (core_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .step_count_o (step_count_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference copy of the shadow words and the frame captured at start
  logic [WIDTH-1:0]      words [N_REG];
  logic [DATA_WIDTH-1:0] cur_frame = '0;

  typedef struct {
    logic              start;
    logic [STEP_W-1:0] n;
    logic              ready;
    logic              valid;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] cnt;
    logic              err;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [DATA_WIDTH-1:0] frame_of();
    logic [DATA_WIDTH-1:0] f;
    f = '0;
    for (int i = 0; i < N_REG; i++) f[i*WIDTH +: WIDTH] = words[i];
    f[DATA_WIDTH-1:N_SPIKES] = '0;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic chk_frame(input string name, input logic [DATA_WIDTH-1:0] exp);
    total++;
    if (data_in_o !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, data_in_o, exp);
    end else begin
      $display("ok   %s frame matches", name);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [WIDTH-1:0] data);
    reg_we_i    = 1'b1;
    reg_waddr_i = AW'(addr);
    reg_wdata_i = data;
    if (addr < N_REG) words[addr] = data;
    tick();
    reg_we_i = 1'b0;
  endtask

  // In the full-check build every start needs all words freshly written
  task automatic refill();
`ifdef SPIKER_READER_FULL_CHECK_EN
    for (int i = 0; i < N_REG; i++) write_word(i, words[i]);
`endif
  endtask

  initial begin
    for (int i = 0; i < N_REG; i++) words[i] = '0;

    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(data_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk_frame("rst_frame", '0);
    rst_i = 1'b0;
    tick();

    // Load the frame; the out-of-range address must be dropped
    for (int i = 0; i < N_REG; i++) write_word(i, 32'hA5A5_0000 + 32'(i));
    write_word(27, 32'hFFFF_FFFF);

    // Three-step run with the core always ready
    tbl[0] = '{1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[1] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0};
    tbl[2] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0};
    tbl[3] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0};
    tbl[4] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0};
    tbl[5] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0};
    tbl[6] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0};
    cur_frame = frame_of();
    for (int r = 0; r < 7; r++) begin
      start_i      = tbl[r].start;
      n_steps_i    = tbl[r].n;
      core_ready_i = tbl[r].ready;
      tick();
      start_i = 1'b0;
      chk($sformatf("t%0d_valid", r), 32'(data_valid_o), 32'(tbl[r].valid));
      chk($sformatf("t%0d_busy", r), 32'(busy_o), 32'(tbl[r].busy));
      chk($sformatf("t%0d_done", r), 32'(done_o), 32'(tbl[r].done));
      chk($sformatf("t%0d_count", r), 32'(step_count_o), 32'(tbl[r].cnt));
      chk($sformatf("t%0d_err", r), 32'(err_o), 32'(tbl[r].err));
      if (tbl[r].valid) chk_frame($sformatf("t%0d_frame", r), cur_frame);
    end
    chk("pad_zero", 32'(data_in_o[DATA_WIDTH-1:N_SPIKES]), 0);
    chk("word24_low", 32'(data_in_o[783:768]), 32'h0018);
    core_ready_i = 1'b0;

    // Stalled core with a shadow write in flight; start during the run
    refill();
    cur_frame = frame_of();
    start_i   = 1'b1;
    n_steps_i = 4'd2;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        write_word(2, 32'hDEAD_BEEF);
      end else begin
        tick();
      end
      chk($sformatf("stall%0d_valid", i), 32'(data_valid_o), 1);
      chk_frame($sformatf("stall%0d_frame", i), cur_frame);
    end
    core_ready_i = 1'b1;
    tick();
    core_ready_i = 1'b0;
    chk("gap_valid", 32'(data_valid_o), 0);
    chk("gap_count", 32'(step_count_o), 1);
    tick();
    chk("present2_valid", 32'(data_valid_o), 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("busy_start_err", 32'(err_o), 1);
    chk("busy_start_still_valid", 32'(data_valid_o), 1);
    core_ready_i = 1'b1;
    tick();
    core_ready_i = 1'b0;
    chk("run2_done", 32'(done_o), 1);
    chk("run2_count", 32'(step_count_o), 2);
    chk("run2_err_sticky", 32'(err_o), 1);
    tick();
    chk("run2_idle_busy", 32'(busy_o), 0);
    chk("run2_hold_frame", 32'(data_in_o[95:64]), 32'hA5A5_0002);
    clear_err_i = 1'b1;
    tick();
    clear_err_i = 1'b0;
    chk("clear_err", 32'(err_o), 0);

    // The deferred write to word 2 appears in the next frame
    refill();
    cur_frame = frame_of();
    start_i   = 1'b1;
    n_steps_i = 4'd1;
    tick();
    start_i = 1'b0;
    chk("run3_word2", data_in_o[95:64], 32'hDEAD_BEEF);
    chk_frame("run3_frame", cur_frame);
    core_ready_i = 1'b1;
    tick();
    core_ready_i = 1'b0;
    chk("run3_done", 32'(done_o), 1);
    chk("run3_count", 32'(step_count_o), 1);
    tick();

    // Zero-step start is an error and does not leave IDLE
    start_i   = 1'b1;
    n_steps_i = 4'd0;
    tick();
    chk("zero_err", 32'(err_o), 1);
    chk("zero_busy", 32'(busy_o), 0);
    clear_err_i = 1'b1;
    tick();
    chk("clear_vs_new_err", 32'(err_o), 1);
    start_i = 1'b0;
    tick();
    clear_err_i = 1'b0;
    chk("clear_err2", 32'(err_o), 0);

    // Reset in the middle of a GAP
    refill();
    start_i      = 1'b1;
    n_steps_i    = 4'd2;
    core_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    chk("pre_rst_gap_valid", 32'(data_valid_o), 0);
    chk("pre_rst_gap_busy", 32'(busy_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i        = 1'b0;
    core_ready_i = 1'b0;
    for (int i = 0; i < N_REG; i++) words[i] = '0;
    chk("mid_rst_valid", 32'(data_valid_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_done", 32'(done_o), 0);
    chk("mid_rst_count", 32'(step_count_o), 0);
    chk("mid_rst_err", 32'(err_o), 0);
    chk_frame("mid_rst_frame", '0);
    refill();
    start_i   = 1'b1;
    n_steps_i = 4'd1;
    tick();
    start_i = 1'b0;
    chk("post_rst_valid", 32'(data_valid_o), 1);
    chk_frame("post_rst_frame", '0);
    core_ready_i = 1'b1;
    tick();
    core_ready_i = 1'b0;
    tick();

`ifdef SPIKER_READER_FULL_CHECK_EN
    // Start is refused until every word has been written
    for (int i = 0; i < N_REG - 1; i++) write_word(i, 32'(i + 1));
    start_i   = 1'b1;
    n_steps_i = 4'd1;
    tick();
    start_i = 1'b0;
    chk("full_reject_err", 32'(err_o), 1);
    chk("full_reject_busy", 32'(busy_o), 0);
    clear_err_i = 1'b1;
    tick();
    clear_err_i = 1'b0;
    write_word(N_REG - 1, 32'h0000_1234);
    cur_frame = frame_of();
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    chk("full_accept_busy", 32'(busy_o), 1);
    chk("full_accept_err", 32'(err_o), 0);
    chk_frame("full_accept_frame", cur_frame);
    core_ready_i = 1'b1;
    tick();
    core_ready_i = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spiker_reader.md
Name: spiker_reader

Overview:
Input-side counterpart of the spiker result path. It collects an input spike frame written word-by-word from the register file into a shadow buffer. On a start command it presents the frame to the spiker core for a programmed number of timesteps, using a valid/ready handshake per timestep. It signals completion and exposes status back to the register file.

Parameters:
WIDTH, 32, register word width in bits
N_SPIKES, 784, number of meaningful input spike bits
DATA_WIDTH, 800, width of the core input vector
N_REG, 25, number of spike input registers; N_REG*WIDTH >= DATA_WIDTH
STEP_W, 4, width of timestep count

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
reg_we_i  in  1  register-file write strobe for a spike word
reg_waddr_i  in  $clog2(N_REG)  spike word index
reg_wdata_i  in  WIDTH  spike word data
start_i  in  1  single-cycle start command
n_steps_i  in  STEP_W  timesteps to present; sampled on accepted start
clear_err_i  in  1  clears err_o
data_in_o  out  DATA_WIDTH  frame driven to the core
data_valid_o  out  1  frame valid for the current timestep
core_ready_i  in  1  core accepts the frame this cycle
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse after the last timestep is accepted
step_count_o  out  STEP_W  timesteps accepted in the current run
err_o  out  1  sticky error flag

Behaviour:
- Reset (any cycle, including mid-run):
  - shadow buffer, frame register and dirty mask cleared.
  - State goes to IDLE.
  - All outputs 0.
  - An in-flight timestep is abandoned without handshake completion.
- Shadow writes: reg_we_i with reg_waddr_i < N_REG stores reg_wdata_i into word reg_waddr_i and sets its dirty bit.
  - Address >= N_REG is ignored; no error.
  - Writes are accepted in every state and never disturb the frame in flight (double buffering).
- Frame mapping: frame bit k = shadow bit k for k < N_SPIKES. Bits [DATA_WIDTH-1:N_SPIKES] are forced to 0.
- FSM states: IDLE, PRESENT, GAP, DONE.
  - IDLE: start_i with n_steps_i != 0 is accepted.
    - frame register <= shadow (the same-cycle write is bypassed in).
    - Step target latched; step_count_o <= 0; dirty mask cleared.
    - Next state PRESENT; data_valid_o is high from the next cycle (1-cycle latency).
    - start_i with n_steps_i == 0 sets err_o and the FSM stays in IDLE.
  - PRESENT: data_valid_o = 1 and data_in_o is held stable.
    - On core_ready_i, step_count_o increments.
    - If the new count equals the target, go to DONE; otherwise go to GAP.
  - GAP: data_valid_o = 0 for exactly one cycle, then return to PRESENT.
  - DONE: done_o = 1 for one cycle, then go to IDLE. step_count_o holds its final value until the next start.
- start_i in any state other than IDLE: ignored and sets err_o.
- err_o is sticky. clear_err_i clears it; if a new error occurs in the same cycle as clear_err_i, err_o stays 1.
- data_in_o holds the last frame after the run ends. Consumers qualify it with data_valid_o only.
- core_ready_i is ignored whenever data_valid_o = 0.

Optional Feature:
SPIKER_READER_FULL_CHECK_EN:
- Defined: a start in IDLE is accepted only if all N_REG dirty bits are set. Otherwise it is rejected, err_o is set and the FSM stays in IDLE.
- Undefined: dirty bits are tracked but never checked. Unwritten words keep their previous contents (0 after reset).

Decomposition:
- Package spiker_adapter_pkg holds:
  - reader_state_e (IDLE/PRESENT/GAP/DONE)
  - constant SPIKE_PAD_W = DATA_WIDTH - N_SPIKES
  - function for the N_REG ceiling computation
- One natural sub-module, spiker_frame_buffer, contains:
  - the shadow words, the dirty mask, and the write-bypass logic
  - outputs: shadow vector and all_dirty

Test Plan:
- Write words 0..24 with value 32'hA5A5_0000+i, start with n_steps=3, core_ready_i tied 1:
  - data_valid_o pattern is 1,0,1,0,1.
  - done_o pulses 1 cycle after the third accept; step_count_o = 3.
  - data_in_o[799:784] = 0.
- core_ready_i low for 5 cycles during PRESENT, with a write to word 2 in that window -> data_valid_o stays 1 and data_in_o is unchanged.
- start during PRESENT -> err_o = 1 and the run continues to done. clear_err_i -> err_o = 0.
- start with n_steps=0 -> err_o = 1, busy_o stays 0.
- rst_i asserted mid-GAP -> next cycle all outputs are 0; a following start produces an all-zero frame.
- With SPIKER_READER_FULL_CHECK_EN and only 24 words written, start -> rejected with err_o = 1. After writing word 24, start is accepted.
